// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: shares one single-port framebuffer RAM between VGA scanout prefetch
// (into a show-ahead FIFO) and a CPU write port; scanout wins only when the FIFO runs low.
// Ports:
//   clk, rst (sync, active-high);
//   VGA side: frame_start, pix_pop, pix_data, pix_valid, underrun (sticky);
//   CPU side: wr_valid, wr_ready, wr_addr, wr_data;
//   RAM side: mem_en, mem_we, mem_addr, mem_wdata, mem_rdata (1-cycle read latency).
// Optional macro VGA_FB_STATS_EN adds the underrun_cnt and wr_stall_cnt counters.
module vga_fb_scheduler #(
  parameter int FB_WIDTH    = 640,
  parameter int FB_HEIGHT   = 480,
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 19,
  parameter int FIFO_DEPTH  = 16,
  parameter int URGENT_LVL  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   pix_pop,
  output logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_valid,
  output logic                   underrun,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [PIXEL_WIDTH-1:0] mem_wdata,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata
`ifdef VGA_FB_STATS_EN
  ,
  output logic [15:0]            underrun_cnt,
  output logic [15:0]            wr_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH:0] NPIX_W = (ADDR_WIDTH + 1)'(NPIX);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    SCAN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [PIXEL_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [CW-1:0]          count_q;
  logic                   inflight_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic                   underrun_q;

  logic [CW-1:0] level;
  logic          urgent, space, scan, empty;
  logic          rd_req, rd_go, wr_go, push, pop;

  assign level  = count_q + CW'(inflight_q);
  assign urgent = level < CW'(URGENT_LVL);
  assign space  = level < CW'(FIFO_DEPTH);
  assign scan   = (state_q == SCAN);
  assign empty  = (count_q == '0);

  // Data returning for a read issued before frame_start is stale.
  assign push = inflight_q && !frame_start;
  assign pop  = pix_pop && !empty && !frame_start;

  always_comb begin
    state_d   = state_q;
    rd_req    = 1'b0;
    wr_go     = 1'b0;
    wr_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      wr_ready = !(scan && urgent);
      if (scan && urgent) rd_req = 1'b1;
      else if (wr_valid)  wr_go  = 1'b1;
      else if (scan && space) rd_req = 1'b1;
    end
    // No read from the old frame on the restart cycle, so the
    // first read after frame_start is always address 0.
    rd_go = rd_req && !frame_start;
    if (rd_go) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr_q;
    end else if (wr_go && ({1'b0, wr_addr} < NPIX_W)) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
    if (frame_start) state_d = SCAN;
    else if (rd_go && rd_addr_q == LAST) state_d = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_FRAME;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_addr_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_go;
      if (frame_start) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        count_q    <= '0;
        rd_addr_q  <= '0;
        underrun_q <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
        if (rd_go && rd_addr_q != LAST) rd_addr_q <= rd_addr_q + 1'b1;
        if (pix_pop && empty) underrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wptr_q] <= mem_rdata;
  end

  assign pix_valid = !rst && !empty;
  assign pix_data  = pix_valid ? fifo_q[rptr_q] : '0;
  assign underrun  = underrun_q;

`ifdef VGA_FB_STATS_EN
  logic [15:0] urun_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      urun_cnt_q <= '0;
    end else if (pix_pop && empty && urun_cnt_q != 16'hFFFF) begin
      urun_cnt_q <= urun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (wr_valid && !wr_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = urun_cnt_q;
  assign wr_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: directed bench for vga_fb_scheduler on a small
// 16x8 framebuffer with a behavioural single-port RAM.
module tb_vga_fb_scheduler;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 8;
  localparam int PW = 12;
  localparam int NP = W * H;

  logic          clk, rst, frame_start, pix_pop;
  logic [PW-1:0] pix_data;
  logic          pix_valid, underrun;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_wdata, mem_rdata;
`ifdef VGA_FB_STATS_EN
  logic [15:0]   underrun_cnt, wr_stall_cnt;
`endif

  vga_fb_scheduler #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_WIDTH(PW),
    .ADDR_WIDTH(AW), .FIFO_DEPTH(16), .URGENT_LVL(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .pix_pop(pix_pop), .pix_data(pix_data),
    .pix_valid(pix_valid), .underrun(underrun),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VGA_FB_STATS_EN
    ,
    .underrun_cnt(underrun_cnt),
    .wr_stall_cnt(wr_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] f(int a);
    return PW'(a * 37 + 'h155);
  endfunction

  function automatic logic [PW-1:0] exp_px(int a);
    return (a == 100) ? 12'hABC : f(a);
  endfunction

  logic [PW-1:0] ram [256];
  int rd_cnt, seq_err, exp_next;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] = f(i);
      mem_rdata <= '0;
      rd_cnt = 0; seq_err = 0; exp_next = 0;
    end else begin
      if (frame_start) begin
        rd_cnt = 0; exp_next = 0;
      end
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      if (mem_en && !mem_we) begin
        mem_rdata <= ram[mem_addr];
        rd_cnt++;
        if (int'(mem_addr) != exp_next) seq_err++;
        exp_next = int'(mem_addr) + 1;
      end
    end
  end

  int n_chk, n_bad;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int k, hs, derr, nv, found;
    n_chk = 0; n_bad = 0;
    clk = 0; rst = 1; frame_start = 0; pix_pop = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_underrun", underrun, 0);
    rst = 0;
    #1;
    chk("wait_wr_ready", wr_ready, 1);
    chk("wait_mem_en", mem_en, 0);

    // fill: 16 sequential reads, then stop
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    repeat (30) @(negedge clk);
    #1;
    chk("fill_rd_cnt", rd_cnt, 16);
    chk("fill_seq", seq_err, 0);
    chk("fill_valid", pix_valid, 1);
    chk("fill_head", pix_data, f(0));
    chk("fill_no17", mem_en, 0);

    // CPU write while FIFO full
    wr_valid = 1; wr_addr = 8'd100; wr_data = 12'hABC;
    #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 100);
    chk("wr_mem_wdata", mem_wdata, 'hABC);
    @(negedge clk); wr_valid = 0;
    #1;
    chk("wr_ram", ram[100], 'hABC);
    chk("wr_no_rd", rd_cnt, 16);

    // pop every cycle with CPU pressure
    k = 0; hs = 0; derr = 0; nv = 0;
    pix_pop = 1; wr_valid = 1;
    for (int i = 0; i < 40; i++) begin
      wr_addr = AW'(120 + i % 8);
      wr_data = f(120 + i % 8);
      #1;
      if (wr_ready) hs++;
      if (!pix_valid) nv++;
      else if (pix_data != exp_px(k)) derr++;
      k++;
      @(negedge clk);
    end
    pix_pop = 0; wr_valid = 0;
    #1;
    chk("drain_data", derr, 0);
    chk("drain_valid", nv, 0);
    chk("drain_underrun", underrun, 0);
    chk("drain_cpu_grants", hs, 13);
    chk("drain_rd_cnt", rd_cnt, 43);

    // empty pop -> underrun; next frame_start clears it
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0; pix_pop = 1;
    #1;
    chk("empty_valid", pix_valid, 0);
    chk("empty_data", pix_data, 0);
    @(negedge clk); pix_pop = 0;
    #1;
    chk("urun_set", underrun, 1);
    chk("urun_data", pix_data, 0);
`ifdef VGA_FB_STATS_EN
    chk("urun_cnt", underrun_cnt, 1);
`endif
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    #1;
    chk("urun_clr", underrun, 0);
`ifdef VGA_FB_STATS_EN
    chk("urun_cnt_clr", underrun_cnt, 0);
`endif

    // frame_start while read of addr 37 is in flight
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      #1;
      pix_pop = pix_valid;
      if (mem_en && !mem_we && mem_addr == 8'd37) found = 1;
    end
    chk("rs_found37", found, 1);
    @(negedge clk); frame_start = 1; pix_pop = 1;
    #1;
    chk("rs_no_rd", mem_en, 0);
    @(negedge clk); frame_start = 0; pix_pop = 0;
    #1;
    chk("rs_valid0", pix_valid, 0);
    chk("rs_rd_en", mem_en, 1);
    chk("rs_rd_addr", mem_addr, 0);
    @(negedge clk);
    #1;
    chk("rs_discard", pix_valid, 0);
    @(negedge clk);
    #1;
    chk("rs_valid1", pix_valid, 1);
    chk("rs_head", pix_data, f(0));
    chk("rs_underrun", underrun, 0);

    // consume the whole frame
    k = 0; derr = 0;
    for (int c = 0; c < 2000 && k < NP; c++) begin
      if (pix_valid) begin
        if (pix_data != exp_px(k)) derr++;
        k++;
        pix_pop = 1;
      end else begin
        pix_pop = 0;
      end
      @(negedge clk);
      #1;
    end
    pix_pop = 0;
    #1;
    chk("frame_pops", k, NP);
    chk("frame_data", derr, 0);
    chk("frame_rd_cnt", rd_cnt, NP);
    chk("frame_seq", seq_err, 0);
    chk("frame_underrun", underrun, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("done_empty", pix_valid, 0);
    chk("done_no_rd", rd_cnt, NP);
    wr_valid = 1; wr_addr = 8'd128; wr_data = 12'h123;
    #1;
    chk("oob_ready", wr_ready, 1);
    chk("oob_mem_en", mem_en, 0);
    wr_addr = 8'd127; wr_data = f(127);
    #1;
    chk("last_mem_en", mem_en, 1);
    chk("last_mem_addr", mem_addr, 127);
    @(negedge clk); wr_valid = 0;
    #1;
    chk("oob_ram", ram[128], f(128));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
